// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator request-side logic.
package elevator_pkg;

  localparam int FLOORS  = 8;
  localparam int FLOOR_W = 3;

  localparam logic [FLOOR_W-1:0] NO_FLOOR = 3'd0;

  localparam logic [1:0] DIR_IDLE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DOWN = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_e;

  // One-hot mask for a floor number.
  function automatic logic [FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    floor_bit = {{(FLOORS-1){1'b0}}, 1'b1} << f;
  endfunction

endpackage

// File: rtl/call_select.sv
// Picks the next floor to present from the candidate set, preferring calls
// ahead of the car in its direction of travel.
module call_select
  import elevator_pkg::*;
(
  input  logic [FLOORS-1:0]  cand,
  input  logic [FLOOR_W-1:0] out_floor,
  input  logic [1:0]         direction,
  output logic [FLOOR_W-1:0] sel_floor,
  output logic               sel_valid
);

  logic [FLOOR_W-1:0] low_ge, low_gt, high_le, high_lt;
  logic               low_ge_v, low_gt_v, high_le_v, high_lt_v;

  // Nearest candidate above/below the car, scanning so the last hit wins.
  always_comb begin
    low_ge = NO_FLOOR;  low_ge_v  = 1'b0;
    low_gt = NO_FLOOR;  low_gt_v  = 1'b0;
    high_le = NO_FLOOR; high_le_v = 1'b0;
    high_lt = NO_FLOOR; high_lt_v = 1'b0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (cand[i] && (FLOOR_W'(i) >= out_floor)) begin
        low_ge = FLOOR_W'(i); low_ge_v = 1'b1;
      end else begin
        low_ge = low_ge;
      end
      if (cand[i] && (FLOOR_W'(i) > out_floor)) begin
        low_gt = FLOOR_W'(i); low_gt_v = 1'b1;
      end else begin
        low_gt = low_gt;
      end
    end
    for (int i = 0; i < FLOORS; i++) begin
      if (cand[i] && (FLOOR_W'(i) <= out_floor)) begin
        high_le = FLOOR_W'(i); high_le_v = 1'b1;
      end else begin
        high_le = high_le;
      end
      if (cand[i] && (FLOOR_W'(i) < out_floor)) begin
        high_lt = FLOOR_W'(i); high_lt_v = 1'b1;
      end else begin
        high_lt = high_lt;
      end
    end
  end

  // Travelling down: serve at-or-below first; otherwise serve at-or-above first.
  always_comb begin
    sel_floor = NO_FLOOR;
    sel_valid = 1'b0;
    if (direction == DIR_DOWN) begin
      if (high_le_v) begin
        sel_floor = high_le; sel_valid = 1'b1;
      end else begin
        sel_floor = low_gt;  sel_valid = low_gt_v;
      end
    end else begin
      if (low_ge_v) begin
        sel_floor = low_ge;  sel_valid = 1'b1;
      end else begin
        sel_floor = high_lt; sel_valid = high_lt_v;
      end
    end
  end

endmodule

// File: rtl/elevator_call_panel.sv
// Latches floor calls into lamps and presents them one at a time to the
// elevator controller, returning req_floor to 0 between presentations.
module elevator_call_panel
  import elevator_pkg::*;
#(
  parameter int HOLD_CYCLES   = 2,
  parameter int GAP_CYCLES    = 1,
  parameter int RESEND_CYCLES = 255,
  parameter int CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOORS-1:0]  call_btn,
  input  logic [FLOOR_W-1:0] out_floor,
  input  logic               complete,
  input  logic [1:0]         direction,
  input  logic               over_weight,
  output logic [FLOOR_W-1:0] req_floor,
  output logic [FLOORS-1:0]  call_lamp,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [FLOORS-1:0]  pending_q, pending_d, sent_q, sent_d, call_lamp_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d, resend_q, resend_d;
  logic [FLOOR_W-1:0] floor_q, floor_d, req_floor_q, req_floor_d;
  logic               busy_q, busy_d;

  logic [FLOORS-1:0]  arrive_s, clr_s, set_s, cand_s, outstanding_s;
  logic [FLOOR_W-1:0] sel_floor_s;
  logic               sel_valid_s;

  call_select u_select (
    .cand      (cand_s),
    .out_floor (out_floor),
    .direction (direction),
    .sel_floor (sel_floor_s),
    .sel_valid (sel_valid_s)
  );

  // Call latching, arrival clearing and resend timeout; floor 0 is never a call.
  always_comb begin
    arrive_s      = complete ? floor_bit(out_floor) : {FLOORS{1'b0}};
    clr_s         = arrive_s & sent_q;
    set_s         = call_btn & ~arrive_s & {{(FLOORS-1){1'b1}}, 1'b0};
    pending_d     = (pending_q | set_s) & ~clr_s;
    cand_s        = pending_q & ~sent_q;
    outstanding_s = pending_q & sent_q;
    sent_d        = sent_q & ~clr_s;
    if ((clr_s != {FLOORS{1'b0}}) || (outstanding_s == {FLOORS{1'b0}})) begin
      resend_d = {CNT_W{1'b0}};
    end else if (resend_q >= CNT_W'(RESEND_CYCLES)) begin
      resend_d = {CNT_W{1'b0}};
      sent_d   = sent_d & ~pending_q;
    end else begin
      resend_d = resend_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    floor_d = floor_q;
    case (state_q)
      IDLE: begin
        if (sel_valid_s && !over_weight) begin
          state_d = PRESENT;
          cnt_d   = {CNT_W{1'b0}};
          floor_d = sel_floor_s;
          sent_d  = sent_d | floor_bit(sel_floor_s);
        end else begin
          state_d = IDLE;
        end
      end
      PRESENT: begin
        if (cnt_q >= CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = GAP;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      GAP: begin
        if (cnt_q >= CNT_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    req_floor_d = (state_d == PRESENT) ? floor_d : NO_FLOOR;
    busy_d      = (state_d != IDLE);
  end

  // State, tracking registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= {FLOORS{1'b0}};
      sent_q      <= {FLOORS{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      resend_q    <= {CNT_W{1'b0}};
      floor_q     <= NO_FLOOR;
      req_floor_q <= NO_FLOOR;
      call_lamp_q <= {FLOORS{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      sent_q      <= sent_d;
      cnt_q       <= cnt_d;
      resend_q    <= resend_d;
      floor_q     <= floor_d;
      req_floor_q <= req_floor_d;
      call_lamp_q <= pending_d;
      busy_q      <= busy_d;
    end
  end

  assign req_floor = req_floor_q;
  assign call_lamp = call_lamp_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed test of the elevator call panel with hand-computed expectations.
module tb_elevator_call_panel;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] call_btn;
  logic [2:0] out_floor;
  logic       complete;
  logic [1:0] direction;
  logic       over_weight;
  logic [2:0] req_floor;
  logic [7:0] call_lamp;
  logic       busy;

  int checks = 0;
  int errors = 0;

  elevator_call_panel dut (
    .clk         (clk),
    .rst         (rst),
    .call_btn    (call_btn),
    .out_floor   (out_floor),
    .complete    (complete),
    .direction   (direction),
    .over_weight (over_weight),
    .req_floor   (req_floor),
    .call_lamp   (call_lamp),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req_chk(input string tag, input logic [2:0] exp);
    check(tag, {5'd0, req_floor}, {5'd0, exp});
  endtask

  task automatic busy_chk(input string tag, input logic exp);
    check(tag, {7'd0, busy}, {7'd0, exp});
  endtask

  initial begin
    int n;
    int seen_zero;
    int extra;
    rst = 1'b1; call_btn = 8'h00; out_floor = 3'd0; complete = 1'b0;
    direction = 2'd0; over_weight = 1'b0;
    step();
    step();
    rst = 1'b0;
    req_chk("rst_req", 3'd0);
    check("rst_lamp", call_lamp, 8'h00);
    busy_chk("rst_busy", 1'b0);

    // 1. asynchronous reset while presenting floor 3
    call_btn = 8'h08;
    step();
    call_btn = 8'h00;
    check("t1_lamp", call_lamp, 8'h08);
    step();
    req_chk("t1_present", 3'd3);
    #2 rst = 1'b1;
    #1;
    req_chk("t1_async_req", 3'd0);
    check("t1_async_lamp", call_lamp, 8'h00);
    busy_chk("t1_async_busy", 1'b0);
    #1 rst = 1'b0;
    step();

    // 2. single call at floor 5, hold/gap timing, arrival clear
    out_floor = 3'd1;
    call_btn = 8'h20;
    step();
    call_btn = 8'h00;
    check("t2_lamp_on", call_lamp, 8'h20);
    req_chk("t2_req_idle", 3'd0);
    step();
    req_chk("t2_hold1", 3'd5);
    busy_chk("t2_busy", 1'b1);
    step();
    req_chk("t2_hold2", 3'd5);
    step();
    req_chk("t2_gap", 3'd0);
    busy_chk("t2_gap_busy", 1'b1);
    step();
    busy_chk("t2_idle_busy", 1'b0);
    complete = 1'b1; out_floor = 3'd5;
    step();
    complete = 1'b0;
    check("t2_lamp_off", call_lamp, 8'h00);
    step();
    req_chk("t2_no_repeat", 3'd0);

    // 3a. travelling down from 4 with calls at 6 and 2: 2 then 6
    out_floor = 3'd4; direction = 2'd2;
    call_btn = 8'h44;
    step();
    call_btn = 8'h00;
    check("t3a_lamp", call_lamp, 8'h44);
    step();
    req_chk("t3a_first", 3'd2);
    step(); step(); step(); step();
    req_chk("t3a_second", 3'd6);
    complete = 1'b1; out_floor = 3'd2;
    step();
    out_floor = 3'd6;
    step();
    complete = 1'b0; out_floor = 3'd4;
    check("t3a_cleared", call_lamp, 8'h00);
    step(); step(); step(); step();

    // 3b. travelling up from 4 with calls at 6 and 2: 6 then 2
    direction = 2'd1;
    call_btn = 8'h44;
    step();
    call_btn = 8'h00;
    step();
    req_chk("t3b_first", 3'd6);
    step(); step(); step(); step();
    req_chk("t3b_second", 3'd2);
    complete = 1'b1; out_floor = 3'd2;
    step();
    out_floor = 3'd6;
    step();
    complete = 1'b0; out_floor = 3'd0; direction = 2'd0;
    check("t3b_cleared", call_lamp, 8'h00);
    step(); step(); step(); step();

    // 4. overload blocks presentation until released
    over_weight = 1'b1;
    call_btn = 8'h08;
    step();
    call_btn = 8'h00;
    check("t4_lamp", call_lamp, 8'h08);
    step(); step();
    req_chk("t4_blocked_req", 3'd0);
    busy_chk("t4_blocked_busy", 1'b0);
    over_weight = 1'b0;
    step();
    req_chk("t4_released", 3'd3);
    complete = 1'b1; out_floor = 3'd3;
    step();
    complete = 1'b0; out_floor = 3'd0;
    check("t4_cleared", call_lamp, 8'h00);
    step(); step(); step(); step();

    // 5. unanswered call at 7 is re-presented after the resend timeout
    call_btn = 8'h80;
    step();
    call_btn = 8'h00;
    step();
    req_chk("t5_first", 3'd7);
    n = 0;
    seen_zero = 0;
    for (int i = 1; i <= 400; i++) begin
      step();
      if (req_floor == 3'd0) seen_zero = 1;
      if (seen_zero != 0 && req_floor == 3'd7) begin
        n = i;
        break;
      end
    end
    check("t5_resend_seen", {7'd0, n != 0}, 8'd1);
    check("t5_resend_window", {7'd0, (n >= 255) && (n <= 260)}, 8'd1);
    complete = 1'b1; out_floor = 3'd7;
    step();
    complete = 1'b0; out_floor = 3'd0;
    check("t5_lamp_off", call_lamp, 8'h00);
    step(); step(); step(); step();
    extra = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (req_floor != 3'd0) extra++;
    end
    check("t5_no_more", extra[7:0], 8'd0);

    // 6. press at the floor the car is already at, and floor 0
    out_floor = 3'd2; complete = 1'b1;
    call_btn = 8'h05;
    step();
    call_btn = 8'h00;
    check("t6_lamp", call_lamp, 8'h00);
    complete = 1'b0;
    step(); step(); step();
    req_chk("t6_req", 3'd0);
    busy_chk("t6_busy", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
